tdm_arbiter: RTL and testbench
==============================

TDM_ARBITER -- requirements
Module: tdm_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter SLOT_LEN, default 8: maximum grant length in cycles, legal range 2..256.
REQ-003 SHALL have localparam IW = clog2(N), minimum 1: the requester index width.
REQ-004 SHALL have localparam TW = clog2(SLOT_LEN), minimum 1: the slot timer width.
REQ-005 SHALL have port clk, input, 1 bit: the clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-007 SHALL have port en, input, 1 bit: when low, no new grant is issued.
REQ-008 SHALL have port req, input, N bits: per-requester request level, held high while the shared resource is wanted.
REQ-009 SHALL have port gnt, output, N bits: one-hot or zero grant, registered.
REQ-010 SHALL have port gnt_id, output, IW bits: index of the current or last granted requester, registered.
REQ-011 SHALL have port busy, output, 1 bit: high while any gnt bit is high.
REQ-012 SHALL have port slot_cnt, output, TW bits: cycles elapsed in the current grant, counting 0..SLOT_LEN-1.

Function
REQ-013 SHALL implement two states, IDLE and GRANT.
REQ-014 SHALL hold a round-robin pointer ptr of IW bits, with range 0..N-1.
REQ-015 In IDLE with en=1 and req!=0, SHALL select the first index i with req[i]=1, searching ptr, ptr+1, ... mod N. On the next edge it SHALL set gnt=1<<i, gnt_id=i, slot_cnt=0 and enter GRANT.
REQ-016 Request-to-grant latency from IDLE SHALL be exactly 1 cycle.
REQ-017 In GRANT, slot_cnt SHALL increment by 1 per cycle.
REQ-018 A grant SHALL end on the edge after req[gnt_id]=0 is sampled, or on the edge after slot_cnt=SLOT_LEN-1 is sampled, whichever comes first.
REQ-019 Grant end SHALL set gnt=0, slot_cnt=0, ptr=(gnt_id+1) mod N, and enter IDLE.
REQ-020 ptr wrap-around SHALL be explicit: gnt_id=N-1 gives ptr=0. This holds for non-power-of-2 N, and ptr SHALL never hold a value >= N.
REQ-021 After every grant, gnt SHALL be 0 for at least one cycle (the bubble cycle) before the next grant.
REQ-022 A requester that hits SLOT_LEN with req still high SHALL lose priority to all other requesters. If it is the sole requester, it SHALL be re-granted after the bubble.
REQ-023 en=0 during GRANT SHALL NOT truncate the current grant. It only blocks the next grant.
REQ-024 Changes to req bits other than req[gnt_id] during GRANT SHALL have no effect until IDLE.
REQ-025 gnt SHALL never have more than one bit set. busy SHALL equal |gnt.
REQ-026 The arbiter SHALL be work-conserving: in IDLE with en=1, any req!=0 SHALL always produce a grant on the next edge.

Reset
REQ-027 When rst=1 at an edge: state=IDLE, gnt=0, gnt_id=0, busy=0, slot_cnt=0, ptr=0.
REQ-028 Reset during GRANT SHALL drop gnt on that same edge, with no bubble preserved and no pointer advance.
REQ-029 rst SHALL take priority over every other input.
REQ-030 The first grant after reset SHALL search from index 0.

Structure
REQ-031 A shared package tdm_arb_pkg SHALL hold the state encoding constants (IDLE, GRANT) and the clog2 function.
REQ-032 The slot timer SHALL be one counter_modN instance with N=SLOT_LEN, ce=(state==GRANT), and rst = rst or grant end. No other sub-modules.
REQ-033 The round-robin search SHALL be combinational within tdm_arbiter, using a rotate-and-priority-encode over the N requesters.

Verification (N=4, SLOT_LEN=8)
REQ-034 Scenario: after reset, req=0101 held. Required: gnt=0001 for 8 cycles, then 1 bubble, then gnt=0100 for 8 cycles, then bubble, then gnt=0001.
REQ-035 Scenario: req=1000 only, dropped after 3 grant cycles. Required: gnt=1000 with slot_cnt 0,1,2,3; gnt=0 on the next edge; ptr=0.
REQ-036 Scenario: req=1111 continuous. Required: grant order 0,1,2,3,0; each grant 8 cycles; 1-cycle gaps; ptr wraps from 3 to 0.
REQ-037 Scenario: en=0 asserted at slot_cnt=2 with req=0011. Required: requester 0 keeps its grant to slot_cnt=7; no grant to requester 1 until en=1, then 1-cycle latency.
REQ-038 Scenario: rst pulsed at slot_cnt=5 of a grant to requester 2. Required: gnt=0 and ptr=0 after that edge; with req=0100 still high, gnt=0100 again 1 cycle after rst drops.
REQ-039 Scenario: req=0010 only, held. Required: the same requester is re-granted every 9 cycles, and gnt is never 0 for more than 1 cycle.

Source files
------------

// File: rtl/tdm_arb_pkg.sv
// Shared definitions for the TDM arbiter: state encoding and width helper.
package tdm_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Ceiling log2, never less than 1 so single-value ranges still get a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tdm_arbiter_counter.sv
// Modulo-N up-counter with clock enable and terminal-count flag.
module counter_modN
  import tdm_arb_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ce) begin
      cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == W'(N - 1));

endmodule

// File: rtl/tdm_arbiter.sv
// Round-robin arbiter with bounded grant slots and a mandatory idle bubble
// between grants.
module tdm_arbiter
  import tdm_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int SLOT_LEN = 8,
  localparam int IW = clog2(N),
  localparam int TW = clog2(SLOT_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic [TW-1:0] slot_cnt
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;

  logic          slot_tc;
  logic          grant_end;
  logic [N-1:0]  req_rot;
  logic [IW-1:0] off;
  logic          found;
  logic [IW:0]   sum;
  logic [IW:0]   sum_wrap;
  logic [IW-1:0] pick;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    req_rot = N'({req, req} >> ptr_q);
    off     = '0;
    found   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off   = IW'(k);
        found = 1'b1;
      end
    end
    sum      = {1'b0, ptr_q} + {1'b0, off};
    sum_wrap = (sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum;
    pick     = sum_wrap[IW-1:0];
  end

  assign grant_end = (state_q == GRANT) && (!req[gnt_id_q] || slot_tc);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d  = GRANT;
          gnt_d    = N'(1) << pick;
          gnt_id_d = pick;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  // Counter idles at zero outside GRANT, so a fresh grant always starts at 0.
  counter_modN #(.N(SLOT_LEN)) u_slot_timer (
    .clk (clk),
    .rst (rst | grant_end),
    .ce  (state_q == GRANT),
    .cnt (slot_cnt),
    .tc  (slot_tc)
  );

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = |gnt_q;

endmodule

// File: tb/tb_tdm_arbiter.sv
// Self-checking bench for tdm_arbiter against a behavioural round-robin model.
module tb_tdm_arbiter;

  localparam int N  = 4;
  localparam int SL = 8;
  localparam int IW = 2;
  localparam int TW = 3;
  localparam int VW = N + IW + 1 + TW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic [TW-1:0] slot_cnt;

  int checks = 0;
  int errors = 0;

  // Model: granted index (-1 when none), last id, elapsed cycles, pointer.
  int m_gnt = -1;
  int m_id  = 0;
  int m_cnt = 0;
  int m_ptr = 0;

  tdm_arbiter #(.N(N), .SLOT_LEN(SL)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .slot_cnt (slot_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_gnt = -1; m_id = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_gnt >= 0) begin
      if (!req[m_gnt] || m_cnt == SL - 1) begin
        m_ptr = (m_gnt + 1) % N;
        m_gnt = -1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (en && req != 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_gnt < 0 && req[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
      end
      m_id  = m_gnt;
      m_cnt = 0;
    end
    #1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g;
    g = (m_gnt >= 0) ? N'(1) << m_gnt : '0;
    return {g, IW'(m_id), (m_gnt >= 0), TW'(m_cnt)};
  endfunction

  task automatic apply_reset();
    rst = 1'b1; en = 1'b1; req = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b1111; rst = 1'b1;
    step(); step();
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || slot_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset outputs: got gnt=%b id=%0d busy=%b cnt=%0d, want all zero", gnt, gnt_id, busy, slot_cnt);
    end
    checks++;
    if (dut.ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL reset ptr: got %0d want 0", dut.ptr_q);
    end
    rst = 1'b0; req = '0;
    step();
  endtask

  task automatic test_alternate();
    int first_len;
    apply_reset();
    req = 4'b0101;
    first_len = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (gnt === 4'b0001 && c < 12) first_len++;
      checks++;
      if ({gnt, gnt_id, busy, slot_cnt} !== exp_vec()) begin
        errors++;
        $display("FAIL alternate cyc %0d: got %h want %h", c, {gnt, gnt_id, busy, slot_cnt}, exp_vec());
      end
      if (c == 9) begin
        checks++;
        if (gnt !== 4'b0100) begin
          errors++;
          $display("FAIL alternate second grant: got %b want 0100", gnt);
        end
      end
    end
    checks++;
    if (first_len != SL) begin
      errors++;
      $display("FAIL alternate first length: got %0d want %0d", first_len, SL);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    req = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (gnt !== 4'b1000 || slot_cnt !== TW'(c)) begin
        errors++;
        $display("FAIL drop grant cyc %0d: got gnt=%b cnt=%0d want 1000/%0d", c, gnt, slot_cnt, c);
      end
    end
    req = '0;
    step();
    checks++;
    if (gnt !== 4'b0000 || dut.ptr_q !== 2'd0 || slot_cnt !== 3'd0) begin
      errors++;
      $display("FAIL drop end: got gnt=%b ptr=%0d cnt=%0d want 0000/0/0", gnt, dut.ptr_q, slot_cnt);
    end
  endtask

  task automatic test_all_req();
    int order[$];
    int want[5] = '{0, 1, 2, 3, 0};
    logic prev_busy;
    apply_reset();
    req = 4'b1111;
    prev_busy = 1'b0;
    for (int c = 0; c < 38; c++) begin
      step();
      if (busy && !prev_busy) order.push_back(int'(gnt_id));
      prev_busy = busy;
      checks++;
      if ({gnt, gnt_id, busy, slot_cnt} !== exp_vec() || dut.ptr_q !== IW'(m_ptr)) begin
        errors++;
        $display("FAIL all_req cyc %0d: got %h ptr=%0d want %h ptr=%0d", c, {gnt, gnt_id, busy, slot_cnt}, dut.ptr_q, exp_vec(), m_ptr);
      end
    end
    checks++;
    if (order.size() < 5) begin
      errors++;
      $display("FAIL all_req order count: got %0d want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != want[i]) begin
          errors++;
          $display("FAIL all_req order[%0d]: got %0d want %0d", i, order[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_en_block();
    apply_reset();
    req = 4'b0011;
    step(); step(); step();
    en = 1'b0;
    for (int c = 0; c < 15; c++) begin
      checks++;
      if ({gnt, gnt_id, busy, slot_cnt} !== exp_vec()) begin
        errors++;
        $display("FAIL en_block cyc %0d: got %h want %h", c, {gnt, gnt_id, busy, slot_cnt}, exp_vec());
      end
      step();
    end
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL en_block held off: got %b want 0000", gnt);
    end
    en = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL en_block release: got %b want 0010", gnt);
    end
  endtask

  task automatic test_rst_mid();
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c < 20 && !(m_gnt == 2 && m_cnt == 5); c++) step();
    checks++;
    if (gnt !== 4'b0100 || slot_cnt !== 3'd5) begin
      errors++;
      $display("FAIL rst_mid setup: got gnt=%b cnt=%0d want 0100/5", gnt, slot_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || dut.ptr_q !== 2'd0 || slot_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid drop: got gnt=%b ptr=%0d cnt=%0d want 0000/0/0", gnt, dut.ptr_q, slot_cnt);
    end
    step();
    checks++;
    if (gnt !== 4'b0100 || slot_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid regrant: got gnt=%b cnt=%0d want 0100/0", gnt, slot_cnt);
    end
  endtask

  task automatic test_sole();
    int zero_run, max_zero, last_start, gaps_bad;
    logic prev_busy;
    apply_reset();
    req = 4'b0010;
    zero_run = 0; max_zero = 0; last_start = -1; gaps_bad = 0; prev_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (c > 0) begin
        zero_run = busy ? 0 : zero_run + 1;
        if (zero_run > max_zero) max_zero = zero_run;
      end
      if (busy && !prev_busy) begin
        if (last_start >= 0 && c - last_start != SL + 1) gaps_bad++;
        last_start = c;
      end
      prev_busy = busy;
      checks++;
      if ({gnt, gnt_id, busy, slot_cnt} !== exp_vec()) begin
        errors++;
        $display("FAIL sole cyc %0d: got %h want %h", c, {gnt, gnt_id, busy, slot_cnt}, exp_vec());
      end
    end
    checks++;
    if (max_zero != 1 || gaps_bad != 0) begin
      errors++;
      $display("FAIL sole spacing: got max_idle=%0d bad_periods=%0d want 1/0", max_zero, gaps_bad);
    end
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      req = N'($urandom);
      if ($urandom_range(3, 0) != 0) req = gnt | req;
      en  = ($urandom_range(7, 0) != 0);
      rst = ($urandom_range(99, 0) == 0);
      step();
      checks++;
      if ({gnt, gnt_id, busy, slot_cnt} !== exp_vec() || dut.ptr_q !== IW'(m_ptr)) begin
        errors++;
        if (bad < 10) $display("FAIL random cyc %0d: got %h ptr=%0d want %h ptr=%0d", c, {gnt, gnt_id, busy, slot_cnt}, dut.ptr_q, exp_vec(), m_ptr);
        bad++;
      end
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_drop();
    test_all_req();
    test_en_block();
    test_rst_mid();
    test_sole();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
